// File: rtl/audio_buf_pkg.sv
// Shared types and width helpers for the audio window buffer.
// Capture and readout FSM state encodings live here so that the top and any
// future analysis-side logic agree on them.
package audio_buf_pkg;

  typedef enum logic {
    CAP_IDLE,
    CAP_WRITE
  } cap_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_OUT
  } rd_state_t;

  // RAM address = {sample pointer, channel}
  function automatic int ram_addr_bits(input int buffer_bits, input int channel_bits);
    return buffer_bits + channel_bits;
  endfunction

  // Words streamed per frame: every channel of every sample in the window
  function automatic int words_per_frame(input int window_bits, input int channel_bits);
    return 1 << (window_bits + channel_bits);
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module sample_ram #(
  parameter int DATA_WIDTH_BITS = 16,
  parameter int ADDR_BITS       = 12
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ADDR_BITS-1:0]       waddr,
  input  logic [DATA_WIDTH_BITS-1:0] wdata,
  input  logic                       re,
  input  logic [ADDR_BITS-1:0]       raddr,
  output logic [DATA_WIDTH_BITS-1:0] rdata
);

  logic [DATA_WIDTH_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];
  logic [DATA_WIDTH_BITS-1:0] rdata_q;

  // Write and registered read share the clock; the read sees pre-write contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/audio_window_buffer.sv
// Multi-channel circular audio capture buffer with hop-based frame readout.
// Optional build macro AWB_INPUT_SYNC_EN: data_ready is treated as an
// asynchronous level, synchronised and edge-detected (3 cycles extra latency).
module audio_window_buffer
  import audio_buf_pkg::*;
#(
  parameter int DATA_WIDTH_BITS  = 16,
  parameter int BUFFER_SIZE_BITS = 11,
  parameter int WINDOW_SIZE_BITS = 8,
  parameter int HOP_SIZE_BITS    = 7,
  parameter int CHANNEL_BITS     = 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [(DATA_WIDTH_BITS<<CHANNEL_BITS)-1:0]   audio,
  input  logic                                         data_ready,
  output logic                                         frame_ready,
  input  logic                                         rd_start,
  output logic [DATA_WIDTH_BITS-1:0]                   m_data,
  output logic [CHANNEL_BITS-1:0]                      m_channel,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic                                         m_last,
  output logic                                         busy,
  output logic                                         err_drop,
  output logic                                         err_overrun,
  input  logic                                         clr_err
);

  localparam int NCH       = 1 << CHANNEL_BITS;
  localparam int WIN       = 1 << WINDOW_SIZE_BITS;
  localparam int HOP       = 1 << HOP_SIZE_BITS;
  localparam int RAM_AW    = ram_addr_bits(BUFFER_SIZE_BITS, CHANNEL_BITS);
  localparam int WPF       = words_per_frame(WINDOW_SIZE_BITS, CHANNEL_BITS);
  localparam int WORD_BITS = WINDOW_SIZE_BITS + CHANNEL_BITS;
  localparam logic [BUFFER_SIZE_BITS-1:0] WIN_PTR   = BUFFER_SIZE_BITS'(WIN);
  localparam logic [BUFFER_SIZE_BITS:0]   WIN_SPAN  = (BUFFER_SIZE_BITS+1)'(WIN);
  localparam logic [WINDOW_SIZE_BITS:0]   WIN_CNT   = (WINDOW_SIZE_BITS+1)'(WIN);
  localparam logic [HOP_SIZE_BITS:0]      HOP_LAST  = (HOP_SIZE_BITS+1)'(HOP-1);
  localparam logic [WORD_BITS-1:0]        WORD_LAST = WORD_BITS'(WPF-1);

  logic strobe;

`ifdef AWB_INPUT_SYNC_EN
  logic [2:0] sync_q;
  logic       strobe_q;

  // Two-flop synchroniser, edge history flop, registered rising-edge pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], data_ready};
      strobe_q <= sync_q[1] & ~sync_q[2];
    end
  end
  assign strobe = strobe_q;
`else
  assign strobe = data_ready;
`endif

  cap_state_t                              cap_state_q, cap_state_d;
  rd_state_t                               rd_state_q, rd_state_d;
  logic [CHANNEL_BITS-1:0]                 wr_ch_q, wr_ch_d;
  logic [BUFFER_SIZE_BITS-1:0]             wr_ptr_q, wr_ptr_d;
  logic [(DATA_WIDTH_BITS<<CHANNEL_BITS)-1:0] audio_q, audio_d;
  logic [WINDOW_SIZE_BITS:0]               count_q, count_d;
  logic [HOP_SIZE_BITS:0]                  hop_q, hop_d;
  logic [BUFFER_SIZE_BITS-1:0]             base_q, base_d;
  logic [BUFFER_SIZE_BITS-1:0]             rd_ptr_q, rd_ptr_d;
  logic [WORD_BITS-1:0]                    rd_word_q, rd_word_d;
  logic pending_q, pending_d, busy_q, busy_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [CHANNEL_BITS-1:0]                 m_channel_q, m_channel_d;
  logic err_drop_q, err_drop_d, err_overrun_q, err_overrun_d;

  logic                          ram_we, ram_re, write_done, frame_evt, rd_accept;
  logic                          drop_set, ovr_set;
  logic [DATA_WIDTH_BITS-1:0]    ram_wdata, ram_rdata;
  logic [CHANNEL_BITS-1:0]       rd_ch;
  logic [WINDOW_SIZE_BITS-1:0]   rd_idx;
  logic [BUFFER_SIZE_BITS:0]     unread, wr_gap;

  assign rd_ch     = rd_word_q[CHANNEL_BITS-1:0];
  assign rd_idx    = rd_word_q[WORD_BITS-1:CHANNEL_BITS];
  assign ram_wdata = audio_q[wr_ch_q*DATA_WIDTH_BITS +: DATA_WIDTH_BITS];
  // Samples of the frame not yet fully streamed, and how far the writer sits ahead of the reader
  assign unread    = WIN_SPAN - (BUFFER_SIZE_BITS+1)'(rd_idx);
  assign wr_gap    = {1'b0, wr_ptr_q - rd_ptr_q};

  // Next-state logic for capture, frame scheduling, readout and error flags
  always_comb begin
    cap_state_d = cap_state_q;
    rd_state_d  = rd_state_q;
    wr_ch_d     = wr_ch_q;
    wr_ptr_d    = wr_ptr_q;
    audio_d     = audio_q;
    count_d     = count_q;
    hop_d       = hop_q;
    base_d      = base_q;
    rd_ptr_d    = rd_ptr_q;
    rd_word_d   = rd_word_q;
    pending_d   = pending_q;
    busy_d      = busy_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_channel_d = m_channel_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    write_done  = 1'b0;
    frame_evt   = 1'b0;
    drop_set    = 1'b0;
    ovr_set     = 1'b0;
    rd_accept   = (rd_state_q == RD_IDLE) && rd_start && pending_q;

    case (cap_state_q)
      CAP_IDLE: begin
        if (strobe) begin
          audio_d     = audio;
          wr_ch_d     = '0;
          cap_state_d = CAP_WRITE;
        end
      end
      default: begin
        ram_we  = 1'b1;
        wr_ch_d = wr_ch_q + 1'b1;
        if (strobe) drop_set = 1'b1;
        // First word of a sample landing inside the unread part of the frame
        if (busy_q && (wr_ch_q == '0) && (wr_gap < unread)) ovr_set = 1'b1;
        if (wr_ch_q == '1) begin
          write_done  = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          cap_state_d = CAP_IDLE;
        end
      end
    endcase

    if (write_done) begin
      count_d   = (count_q == WIN_CNT) ? count_q : count_q + 1'b1;
      hop_d     = (hop_q == HOP_LAST) ? '0 : hop_q + 1'b1;
      frame_evt = (hop_q == HOP_LAST) && (count_d == WIN_CNT);
    end

    case (rd_state_q)
      RD_IDLE: begin
        if (rd_accept) begin
          pending_d  = 1'b0;
          busy_d     = 1'b1;
          rd_ptr_d   = base_q;
          rd_word_d  = '0;
          rd_state_d = RD_FETCH;
        end
      end
      RD_FETCH: begin
        ram_re      = 1'b1;
        m_valid_d   = 1'b1;
        m_channel_d = rd_ch;
        m_last_d    = (rd_word_q == WORD_LAST);
        rd_state_d  = RD_OUT;
      end
      default: begin
        if (m_ready) begin
          m_valid_d   = 1'b0;
          m_last_d    = 1'b0;
          m_channel_d = '0;
          if (m_last_q) begin
            busy_d     = 1'b0;
            rd_state_d = RD_IDLE;
          end else begin
            rd_word_d  = rd_word_q + 1'b1;
            if (rd_ch == '1) rd_ptr_d = rd_ptr_q + 1'b1;
            rd_state_d = RD_FETCH;
          end
        end
      end
    endcase

    // A new frame overrides an unread one; a same-cycle start has already taken the old base
    if (frame_evt) begin
      base_d    = wr_ptr_d - WIN_PTR;
      pending_d = 1'b1;
      if (pending_q && !rd_accept) drop_set = 1'b1;
    end

    err_drop_d    = clr_err ? 1'b0 : (err_drop_q | drop_set);
    err_overrun_d = clr_err ? 1'b0 : (err_overrun_q | ovr_set);
  end

  // Control state is reset; sample data and pointers gated by control are not
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_state_q   <= CAP_IDLE;
      rd_state_q    <= RD_IDLE;
      wr_ch_q       <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      hop_q         <= '0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_channel_q   <= '0;
      err_drop_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      cap_state_q   <= cap_state_d;
      rd_state_q    <= rd_state_d;
      wr_ch_q       <= wr_ch_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      hop_q         <= hop_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_channel_q   <= m_channel_d;
      err_drop_q    <= err_drop_d;
      err_overrun_q <= err_overrun_d;
    end
    audio_q   <= audio_d;
    base_q    <= base_d;
    rd_ptr_q  <= rd_ptr_d;
    rd_word_q <= rd_word_d;
  end

  sample_ram #(
    .DATA_WIDTH_BITS (DATA_WIDTH_BITS),
    .ADDR_BITS       (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({wr_ptr_q, wr_ch_q}),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr ({rd_ptr_q, rd_ch}),
    .rdata (ram_rdata)
  );

  assign frame_ready = pending_q;
  assign busy        = busy_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_valid_q ? ram_rdata : '0;
  assign m_channel   = m_channel_q;
  assign m_last      = m_last_q;
  assign err_drop    = err_drop_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_audio_window_buffer.sv
// Scoreboard bench for audio_window_buffer (small buffer configuration).
module tb_audio_window_buffer;

  localparam int DW = 16, BB = 5, WB = 3, HB = 2, CB = 1;
  localparam int NC = 2, WIN = 8, HOP = 4, NBUF = 32;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [31:0]   audio = '0;
  logic          data_ready = 1'b0, rd_start = 1'b0, m_ready = 1'b0, clr_err = 1'b0;
  logic          frame_ready, m_valid, m_last, busy, err_drop, err_overrun;
  logic [DW-1:0] m_data;
  logic [CB-1:0] m_channel;

  audio_window_buffer #(
    .DATA_WIDTH_BITS (DW), .BUFFER_SIZE_BITS (BB), .WINDOW_SIZE_BITS (WB),
    .HOP_SIZE_BITS (HB), .CHANNEL_BITS (CB)
  ) dut (
    .clk (clk), .rst_n (rst_n), .audio (audio), .data_ready (data_ready),
    .frame_ready (frame_ready), .rd_start (rd_start), .m_data (m_data),
    .m_channel (m_channel), .m_valid (m_valid), .m_ready (m_ready), .m_last (m_last),
    .busy (busy), .err_drop (err_drop), .err_overrun (err_overrun), .clr_err (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CB-1:0] ch;
    logic          last;
    logic          chk;
  } word_t;

  word_t exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0;

  // Reference model: history of accepted sample vectors and frame bookkeeping
  logic [DW-1:0] hist0[$], hist1[$];
  int acc_cnt, last_acc, pend_start, last_frame_end, ovr_end;
  bit m_pend, exp_drop, exp_ovr, ovr_on;
  int ready_mode = 0;  // 0: hold low, 1: hold high, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist0.delete(); hist1.delete();
    acc_cnt = 0; last_acc = -100; pend_start = 0; last_frame_end = 0;
    m_pend = 0; exp_drop = 0; exp_ovr = 0; ovr_on = 0;
  endtask

  // A strobe is taken only if the previous accepted one finished its C-word write
  task automatic model_sample(input logic [DW-1:0] s0, input logic [DW-1:0] s1, input int edge_n);
    if (edge_n - last_acc >= NC + 1) begin
      last_acc = edge_n;
      hist0.push_back(s0); hist1.push_back(s1);
      acc_cnt++;
      if (acc_cnt >= WIN && (acc_cnt % HOP) == 0) begin
        if (m_pend) exp_drop = 1;
        m_pend = 1;
        pend_start = acc_cnt - WIN;
      end
      if (ovr_on && (acc_cnt - ovr_end) > (NBUF - WIN)) exp_ovr = 1;
    end else begin
      exp_drop = 1;
    end
  endtask

  task automatic strobe(input logic [DW-1:0] s0, input logic [DW-1:0] s1);
    @(posedge clk); #1;
    audio = {s1, s0}; data_ready = 1'b1;
    @(posedge clk); #1;
    model_sample(s0, s1, cyc);
    data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic double_strobe(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge clk); #1;
    audio = {a, a}; data_ready = 1'b1;
    @(posedge clk); #1;
    model_sample(a, a, cyc);
    audio = {b, b};
    @(posedge clk); #1;
    model_sample(b, b, cyc);
    data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clr_err = 1'b1;
    exp_drop = 0; exp_ovr = 0;
    @(posedge clk); #1; clr_err = 1'b0;
  endtask

  task automatic start_frame(input bit chk);
    word_t w;
    repeat (2) @(posedge clk);
    #1;
    check("frame_ready_before_start", 32'(frame_ready), 32'(m_pend));
    if (m_pend) begin
      for (int i = 0; i < WIN; i++) begin
        for (int c = 0; c < NC; c++) begin
          w.data = (c == 0) ? hist0[pend_start + i] : hist1[pend_start + i];
          w.ch   = CB'(c);
          w.last = (i == WIN - 1) && (c == NC - 1);
          w.chk  = chk;
          exp_q.push_back(w);
        end
      end
      last_frame_end = pend_start + WIN;
      m_pend = 0;
    end
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 800) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 800) begin
      failures++;
      $display("FAIL readout_timeout words_left=%0d required=0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_frame_ready", 32'(frame_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_channel", 32'(m_channel), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err_drop", 32'(err_drop), 0);
    check("rst_err_overrun", 32'(err_overrun), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic fill_counting(input int first, input int num);
    for (int n = first; n < first + num; n++) begin
      strobe(DW'(n), DW'(100 + n));
      if (n == first + num - 2) check("frame_ready_one_short", 32'(frame_ready), 32'(m_pend));
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold-stability under backpressure
  logic          stall_v = 1'b0;
  logic [DW-1:0] stall_d;
  logic [CB-1:0] stall_c;
  logic          stall_l;
  always @(negedge clk) begin
    word_t w;
    if (!rst_n) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        check("stall_m_valid", 32'(m_valid), 1);
        check("stall_m_data", 32'(m_data), 32'(stall_d));
        check("stall_m_channel", 32'(m_channel), 32'(stall_c));
        check("stall_m_last", 32'(m_last), 32'(stall_l));
      end
      stall_v = m_valid && !m_ready;
      stall_d = m_data; stall_c = m_channel; stall_l = m_last;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word actual=%0d required=no_word", m_data);
        end else begin
          w = exp_q.pop_front();
          if (w.chk) check("m_data", 32'(m_data), 32'(w.data));
          check("m_channel", 32'(m_channel), 32'(w.ch));
          check("m_last", 32'(m_last), 32'(w.last));
        end
      end
    end
  end

  initial begin
    int n;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // 1: first window of counting samples
    fill_counting(0, 8);
    ready_mode = 1;
    start_frame(1);
    wait_done();

    // 2 + 3: one hop later, overlapped window, with a 10-cycle stall mid-frame
    fill_counting(8, 4);
    ready_mode = 1;
    start_frame(1);
    n = 0;
    while (exp_q.size() > 8 && n < 200) begin @(negedge clk); n++; end
    ready_mode = 0;
    repeat (10) @(posedge clk);
    ready_mode = 1;
    wait_done();
    check("err_drop_clean", 32'(err_drop), 32'(exp_drop));

    // 4: dropped strobe, clear, then an unread frame replaced by a newer one
    double_strobe(16'h1111, 16'h2222);
    check("err_drop_strobe", 32'(err_drop), 32'(exp_drop));
    pulse_clr();
    #1 check("err_drop_cleared", 32'(err_drop), 32'(exp_drop));
    for (int i = 0; i < 8; i++) strobe(DW'($urandom), DW'($urandom));
    check("err_drop_frame", 32'(err_drop), 32'(exp_drop));
    check("frame_ready_pending", 32'(frame_ready), 32'(m_pend));

    // 5: stalled readout while the writer laps the buffer
    ready_mode = 0;
    start_frame(0);
    ovr_on = 1; ovr_end = last_frame_end;
    for (int i = 0; i < 40; i++) begin
      strobe(DW'($urandom), DW'($urandom));
      check("err_overrun", 32'(err_overrun), 32'(exp_ovr));
      if (exp_ovr) break;
    end
    ready_mode = 2;
    wait_done();
    ovr_on = 0;
    check("err_overrun_sticky", 32'(err_overrun), 1);

    // 6: reset in the middle of a readout, then a fresh fill
    ready_mode = 1;
    start_frame(1);
    n = 0;
    while (exp_q.size() > 10 && n < 200) begin @(negedge clk); n++; end
    ready_mode = 0;
    do_reset();
    fill_counting(0, 8);
    ready_mode = 2;
    start_frame(1);
    wait_done();
    check("final_err_drop", 32'(err_drop), 32'(exp_drop));
    check("final_err_overrun", 32'(err_overrun), 32'(exp_ovr));
    check("final_frame_ready", 32'(frame_ready), 32'(m_pend));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
